// File: rtl/blink_sequencer.sv
// blink_sequencer
// Arbitrates error/success blink requests onto one shared LED blinker.
// Requests are edge-detected and latched as sticky pending flags. Error wins
// over success. Each grant produces a one-cycle start pulse. The sequencer then
// waits for the blinker to finish and holds a dark gap before the next grant.
// A shared watchdog timer recovers from a blinker that never acknowledges or
// never finishes, and latches a sticky fault when that happens.
//
// Ports:
//   hwclk       - single clock, rising edge
//   rst         - asynchronous active-high reset
//   err_req     - error pattern request (rising edge counted)
//   ok_req      - success pattern request (rising edge counted)
//   blink_done  - from blinker: high when idle/finished, low while blinking
//   blink_start - one-cycle start pulse to blinker
//   blink_type  - pattern select: 0 = error, 1 = success
//   busy        - sequencer not idle, or a request is pending
//   err_pend    - error request latched, not yet granted
//   ok_pend     - success request latched, not yet granted
//   fault       - sticky ACK/pattern timeout flag, cleared only by rst
module blink_sequencer #(
  parameter logic [31:0] GAP_CYCLES     = 32'd6000000,
  parameter logic [7:0]  ACK_CYCLES     = 8'd8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd240000000
) (
  input  logic hwclk,
  input  logic rst,
  input  logic err_req,
  input  logic ok_req,
  input  logic blink_done,
  output logic blink_start,
  output logic blink_type,
  output logic busy,
  output logic err_pend,
  output logic ok_pend,
  output logic fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ACK   = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        err_req_q, ok_req_q;
  logic        err_pend_q, err_pend_d;
  logic        ok_pend_q, ok_pend_d;
  logic        type_q, type_d;
  logic        fault_q, fault_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        grant_err_s, grant_ok_s;

  // True once a state has lasted 'lim' cycles (timer counts from 0 on entry).
  // A zero limit expires immediately so the state lasts one cycle.
  function automatic logic limit_hit(input logic [31:0] t, input logic [31:0] lim);
    if (lim == 32'd0) begin
      limit_hit = 1'b1;
    end else begin
      limit_hit = (t >= (lim - 32'd1));
    end
  endfunction

  // Next-state, grant, fault, timer and registered-output decode.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    fault_d     = fault_q;
    grant_err_s = 1'b0;
    grant_ok_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (err_pend_q) begin
          grant_err_s = 1'b1;
          type_d      = 1'b0;
          state_d     = S_START;
        end else if (ok_pend_q) begin
          grant_ok_s  = 1'b1;
          type_d      = 1'b1;
          state_d     = S_START;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        // Seeing the acknowledge wins over an expiring deadline in the same cycle.
        if (!blink_done) begin
          state_d = S_RUN;
        end else if (limit_hit(timer_q, {24'd0, ACK_CYCLES})) begin
          fault_d = 1'b1;
          state_d = S_GAP;
        end else begin
          state_d = S_ACK;
        end
      end
      S_RUN: begin
        if (blink_done) begin
          state_d = S_GAP;
        end else if (limit_hit(timer_q, TIMEOUT_CYCLES)) begin
          fault_d = 1'b1;
          state_d = S_GAP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_GAP: begin
        if (limit_hit(timer_q, GAP_CYCLES)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // One shared timer, zeroed on every state change, saturating instead of wrapping.
    if (state_d != state_q) begin
      timer_d = 32'd0;
    end else if (timer_q == 32'hFFFF_FFFF) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    // A new rising edge sets the flag even in the cycle its grant clears it.
    err_pend_d = (err_pend_q & ~grant_err_s) | (err_req & ~err_req_q);
    ok_pend_d  = (ok_pend_q  & ~grant_ok_s)  | (ok_req  & ~ok_req_q);

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE) | err_pend_d | ok_pend_d;
  end

  // State, timer, request history, pending flags and registered outputs.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 32'd0;
      err_req_q  <= 1'b0;
      ok_req_q   <= 1'b0;
      err_pend_q <= 1'b0;
      ok_pend_q  <= 1'b0;
      type_q     <= 1'b0;
      fault_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_req_q  <= err_req;
      ok_req_q   <= ok_req;
      err_pend_q <= err_pend_d;
      ok_pend_q  <= ok_pend_d;
      type_q     <= type_d;
      fault_q    <= fault_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  assign blink_start = start_q;
  assign blink_type  = type_q;
  assign busy        = busy_q;
  assign err_pend    = err_pend_q;
  assign ok_pend     = ok_pend_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: reset checks, a table of
// cycle-by-cycle vectors, hand-written corner sequences (pattern timeout,
// reset mid-pattern) and a randomized run against a reference model that
// tracks the sequencer by absolute cycle numbers.
module tb_blink_sequencer;
  localparam int GAP = 5;
  localparam int ACK = 8;
  localparam int TMO = 1000;

  logic hwclk = 1'b0;
  logic rst, err_req, ok_req, blink_done;
  logic blink_start, blink_type, busy, err_pend, ok_pend, fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 hwclk = ~hwclk;

  blink_sequencer #(
    .GAP_CYCLES    (32'd5),
    .ACK_CYCLES    (8'd8),
    .TIMEOUT_CYCLES(32'd1000)
  ) dut (
    .hwclk      (hwclk),
    .rst        (rst),
    .err_req    (err_req),
    .ok_req     (ok_req),
    .blink_done (blink_done),
    .blink_start(blink_start),
    .blink_type (blink_type),
    .busy       (busy),
    .err_pend   (err_pend),
    .ok_pend    (ok_pend),
    .fault      (fault)
  );

  function automatic logic [5:0] outs();
    return {blink_start, blink_type, busy, err_pend, ok_pend, fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 start, 2 wait-ack, 3 running, 4 gap.
  int m_phase, m_edge, m_entry;
  bit m_pe, m_po, m_ep, m_op, m_type, m_fault;

  task automatic model_reset();
    m_phase = 0; m_entry = m_edge;
    m_pe = 0; m_po = 0; m_ep = 0; m_op = 0; m_type = 0; m_fault = 0;
  endtask

  task automatic model_edge(input bit e, input bit o, input bit d);
    int spent;
    int nxt;
    bit ge, go;
    ge = 0; go = 0;
    m_edge++;
    spent = m_edge - m_entry;   // cycles already spent in the current phase
    nxt = m_phase;
    if (m_phase == 0) begin
      if (m_ep) begin ge = 1; m_type = 0; nxt = 1; end
      else if (m_op) begin go = 1; m_type = 1; nxt = 1; end
    end else if (m_phase == 1) begin
      nxt = 2;
    end else if (m_phase == 2) begin
      if (!d) nxt = 3;
      else if (spent >= ACK) begin m_fault = 1; nxt = 4; end
    end else if (m_phase == 3) begin
      if (d) nxt = 4;
      else if (spent >= TMO) begin m_fault = 1; nxt = 4; end
    end else begin
      if (spent >= GAP) nxt = 0;
    end
    m_ep = (m_ep && !ge) || (e && !m_pe);
    m_op = (m_op && !go) || (o && !m_po);
    m_pe = e; m_po = o;
    if (nxt != m_phase) m_entry = m_edge;
    m_phase = nxt;
  endtask

  function automatic logic [5:0] model_outs();
    return {m_phase == 1, m_type, (m_phase != 0) || m_ep || m_op, m_ep, m_op, m_fault};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int         rep;
    logic       e;
    logic       o;
    logic       d;
    logic [5:0] exp;   // {start, type, busy, err_pend, ok_pend, fault}
  } vec_t;

  vec_t tbl[12];

  initial begin
    int starts;
    int lat;

    // ok pattern, err arrives during it and is served after the gap,
    // then the blinker never acknowledges so the ACK watchdog fires.
    tbl[0]  = '{1, 1'b0, 1'b1, 1'b1, 6'b001010};
    tbl[1]  = '{1, 1'b0, 1'b0, 1'b1, 6'b111000};
    tbl[2]  = '{1, 1'b0, 1'b0, 1'b0, 6'b011000};
    tbl[3]  = '{2, 1'b0, 1'b0, 1'b0, 6'b011000};
    tbl[4]  = '{1, 1'b1, 1'b0, 1'b1, 6'b011100};
    tbl[5]  = '{4, 1'b1, 1'b0, 1'b1, 6'b011100};
    tbl[6]  = '{1, 1'b0, 1'b0, 1'b1, 6'b011100};
    tbl[7]  = '{1, 1'b0, 1'b0, 1'b1, 6'b101000};
    tbl[8]  = '{8, 1'b0, 1'b0, 1'b1, 6'b001000};
    tbl[9]  = '{1, 1'b0, 1'b0, 1'b1, 6'b001001};
    tbl[10] = '{4, 1'b0, 1'b0, 1'b1, 6'b001001};
    tbl[11] = '{1, 1'b0, 1'b0, 1'b1, 6'b000001};

    rst = 1'b1; err_req = 1'b0; ok_req = 1'b0; blink_done = 1'b1;
    m_edge = 0;
    #1;
    check("reset_async", outs(), 6'b000000);
    tick(); tick();
    check("reset_held", outs(), 6'b000000);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        err_req = tbl[r].e; ok_req = tbl[r].o; blink_done = tbl[r].d;
        tick();
        check($sformatf("vec_row%0d_cyc%0d", r, k), outs(), tbl[r].exp);
      end
    end

    // Request-to-start latency, then a pattern that never finishes.
    rst = 1'b1; tick(); rst = 1'b0;
    ok_req = 1'b1; blink_done = 1'b1;
    tick();
    check("lat_pend", {ok_pend, blink_start}, 2'b10);
    ok_req = 1'b0;
    tick();
    check("lat_start", {blink_start, blink_type}, 2'b11);
    blink_done = 1'b0;
    tick();
    check("single_start_pulse", blink_start, 1'b0);
    tick();   // acknowledge seen here: running from this edge
    lat = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (fault) begin lat = i; break; end
    end
    check("run_timeout_latency", lat, 1000);
    blink_done = 1'b1;
    repeat (GAP) tick();
    check("post_timeout_idle", {busy, fault}, 2'b01);

    // Reset while a pattern runs with an error request pending.
    rst = 1'b1; tick(); rst = 1'b0;
    ok_req = 1'b1; tick(); ok_req = 1'b0; tick();
    blink_done = 1'b0; tick(); tick();
    err_req = 1'b1; tick(); err_req = 1'b0;
    check("mid_run_err_pend", {err_pend, busy}, 2'b11);
    @(negedge hwclk);
    rst = 1'b1;
    #1;
    check("reset_mid_run", outs(), 6'b000000);
    tick();
    rst = 1'b0; blink_done = 1'b1;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (blink_start) starts++;
    end
    check("no_start_after_reset", starts, 0);
    check("idle_after_reset", busy, 1'b0);
    err_req = 1'b1; tick(); err_req = 1'b0; tick();
    check("served_after_reset", {blink_start, blink_type}, 2'b10);

    // Randomized run against the reference model.
    rst = 1'b1; err_req = 1'b0; ok_req = 1'b0; blink_done = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 11) == 0) err_req = ~err_req;
      if ($urandom_range(0, 9) == 0)  ok_req = ~ok_req;
      if ($urandom_range(0, 5) == 0)  blink_done = ~blink_done;
      tick();
      if (rst) begin
        m_edge++;
        model_reset();
      end else begin
        model_edge(err_req, ok_req, blink_done);
      end
      check($sformatf("rand_cyc%0d", i), outs(), model_outs());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
